// File: rtl/sprite_dma_ctrl.sv
// ============================================================================
// Module   : sprite_dma_ctrl
// Purpose  : Vblank-synchronised copy of CPU work RAM into sprite RAM, taking
//            the CPU bus through the busrq_n/busak_n handshake.
// Options  : SPRITE_DMA_IRQ_EN enables the completion interrupt on irq_n.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_dma_ctrl #(
    parameter int DST_AW = 7,
    parameter int SRC_AW = 16
) (
    input  logic              clk_24,
    input  logic              reset_n,
    input  logic              vblank,
    input  logic              reg_cs,
    input  logic              reg_wr,
    input  logic [1:0]        reg_addr,
    input  logic [7:0]        reg_din,
    output logic [7:0]        reg_dout,
    output logic              busrq_n,
    input  logic              busak_n,
    output logic              dma_active,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic [DST_AW-1:0] dst_addr,
    output logic              dst_wr,
    output logic [7:0]        dst_data,
    output logic              irq_n
);

    localparam int MAX_LEN = 2 ** DST_AW;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_VB = 3'd1,
        S_REQ     = 3'd2,
        S_XFER    = 3'd3,
        S_REL     = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_wr_d;
    logic [7:0]          r_src_lo;
    logic [7:0]          r_src_hi;
    logic [7:0]          r_len;
    logic                r_done;
    logic [DST_AW:0]     r_cnt;
    logic [DST_AW:0]     r_n;
    logic                r_busrq_n;
    logic                r_active;
    logic [SRC_AW-1:0]   r_src_addr;
    logic [DST_AW-1:0]   r_dst_addr;
    logic                r_dst_wr;

    logic                w_wr_pulse;
    logic                w_ctrl_wr;
    logic                w_busy;
    logic [DST_AW:0]     w_len_eff;
    logic [SRC_AW-1:0]   w_src_start;

    // One register update per CPU write strobe, however long it is held
    assign w_wr_pulse  = reg_cs & reg_wr & ~r_wr_d;
    assign w_ctrl_wr   = w_wr_pulse & (reg_addr == 2'd3);
    assign w_busy      = (r_state != S_IDLE);
    assign w_src_start = SRC_AW'({r_src_hi, r_src_lo});

    always_comb begin
        w_len_eff = (DST_AW+1)'(r_len);
        if (r_len == 8'd0 || 32'(r_len) > 32'(MAX_LEN))
            w_len_eff = (DST_AW+1)'(MAX_LEN);
    end

    always_comb begin
        reg_dout = 8'h00;
        case (reg_addr)
            2'd0: reg_dout = r_src_lo;
            2'd1: reg_dout = r_src_hi;
            2'd2: reg_dout = r_len;
            default: reg_dout = {r_done, 5'b0, (r_state == S_WAIT_VB), w_busy};
        endcase
    end

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wr_d     <= 1'b0;
            r_src_lo   <= 8'h00;
            r_src_hi   <= 8'h00;
            r_len      <= 8'h00;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_n        <= '0;
            r_busrq_n  <= 1'b1;
            r_active   <= 1'b0;
            r_src_addr <= '0;
            r_dst_addr <= '0;
            r_dst_wr   <= 1'b0;
        end else begin
            r_wr_d <= reg_cs & reg_wr;
            if (w_wr_pulse && !w_busy) begin
                case (reg_addr)
                    2'd0:    r_src_lo <= reg_din;
                    2'd1:    r_src_hi <= reg_din;
                    2'd2:    r_len    <= reg_din;
                    default: ;
                endcase
            end
            case (r_state)
                S_IDLE: begin
                    if (w_ctrl_wr && reg_din[0]) begin
                        r_n <= w_len_eff;
                        if (reg_din[1]) begin
                            r_state <= S_WAIT_VB;
                        end else begin
                            r_state   <= S_REQ;
                            r_busrq_n <= 1'b0;
                        end
                    end
                end
                S_WAIT_VB: begin
                    if (vblank) begin
                        r_state   <= S_REQ;
                        r_busrq_n <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!busak_n) begin
                        r_state    <= S_XFER;
                        r_active   <= 1'b1;
                        r_src_addr <= w_src_start;
                        r_cnt      <= '0;
                    end
                end
                S_XFER: begin
                    // Read of byte k overlaps the write of byte k-1
                    if (r_cnt == r_n) begin
                        r_state   <= S_REL;
                        r_active  <= 1'b0;
                        r_busrq_n <= 1'b1;
                        r_dst_wr  <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_src_addr <= r_src_addr + SRC_AW'(1);
                        r_dst_addr <= r_cnt[DST_AW-1:0];
                        r_dst_wr   <= 1'b1;
                        r_cnt      <= r_cnt + (DST_AW+1)'(1);
                    end
                end
                S_REL: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // A CTRL write landing together with completion leaves DONE clear
            if (w_ctrl_wr)
                r_done <= 1'b0;
        end
    end

    assign busrq_n    = r_busrq_n;
    assign dma_active = r_active;
    assign src_addr   = r_src_addr;
    assign dst_addr   = r_dst_addr;
    assign dst_wr     = r_dst_wr;
    // wkram data arrives combinationally in the write cycle; gate it so idle output is 0
    assign dst_data   = r_dst_wr ? src_data : 8'h00;

`ifdef SPRITE_DMA_IRQ_EN
    logic r_irq_n;
    logic w_st_rd;

    assign w_st_rd = reg_cs & ~reg_wr & (reg_addr == 2'd3);

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_n <= 1'b1;
        end else begin
            if (r_state == S_REL)
                r_irq_n <= 1'b0;
            if (w_ctrl_wr || w_st_rd)
                r_irq_n <= 1'b1;
        end
    end

    assign irq_n = r_irq_n;
`else
    assign irq_n = 1'b1;
`endif

endmodule

`default_nettype wire
